// File: rtl/control_unit.sv
// K&S processor sequencer: fetch -> decode -> execute until I_HALT, driving data_path and RAM strobes.
// Optional retired-instruction counter enabled by defining CU_RETIRED_CNT_EN.
package k_and_s_pkg;
    typedef enum logic [3:0] {
        I_NOP    = 4'd0,
        I_LOAD   = 4'd1,
        I_STORE  = 4'd2,
        I_MOVE   = 4'd3,
        I_ADD    = 4'd4,
        I_SUB    = 4'd5,
        I_AND    = 4'd6,
        I_OR     = 4'd7,
        I_BRANCH = 4'd8,
        I_BZERO  = 4'd9,
        I_BNZERO = 4'd10,
        I_BNEG   = 4'd11,
        I_BNNEG  = 4'd12,
        I_BOV    = 4'd13,
        I_BNOV   = 4'd14,
        I_HALT   = 4'd15
    } decoded_instruction_type;
endpackage

module control_unit
    import k_and_s_pkg::*;
#(
    parameter int unsigned RAM_LATENCY = 1,
    parameter int unsigned RET_CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  decoded_instruction_type decoded_instruction,
    input  logic                    zero_op,
    input  logic                    neg_op,
    input  logic                    unsigned_overflow,
    input  logic                    signed_overflow,
    output logic                    branch,
    output logic                    pc_enable,
    output logic                    ir_enable,
    output logic                    addr_sel,
    output logic                    c_sel,
    output logic [1:0]              operation,
    output logic                    write_reg_enable,
    output logic                    flags_reg_enable,
    output logic                    ram_write_enable,
    output logic                    halt
`ifdef CU_RETIRED_CNT_EN
    ,
    output logic [RET_CNT_W-1:0]    retired_count
`endif
);

    if (RAM_LATENCY < 1) begin : g_bad_latency
        $error("control_unit: RAM_LATENCY must be at least 1");
    end

    localparam int unsigned WCW = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;
    localparam logic [WCW-1:0] LAST_WAIT = WCW'(RAM_LATENCY - 1);

    typedef enum logic [2:0] {
        FETCH, DECODE, EXEC_ALU, LOAD_WAIT, STORE, HALT
    } state_t;

    state_t         state_q, state_d;
    logic [WCW-1:0] wait_q, wait_d;
    logic [1:0]     alu_op_q, alu_op_d;
    logic           alu_flags_q, alu_flags_d;

    logic       br_c, pc_c, ir_c, as_c, cs_c, wr_c, fl_c, rw_c, halt_c;
    logic [1:0] op_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FETCH;
            wait_q      <= '0;
            alu_op_q    <= 2'b00;
            alu_flags_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            alu_op_q    <= alu_op_d;
            alu_flags_q <= alu_flags_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        alu_op_d    = alu_op_q;
        alu_flags_d = alu_flags_q;
        br_c   = 1'b0;
        pc_c   = 1'b0;
        ir_c   = 1'b0;
        as_c   = 1'b0;
        cs_c   = 1'b0;
        op_c   = 2'b00;
        wr_c   = 1'b0;
        fl_c   = 1'b0;
        rw_c   = 1'b0;
        halt_c = 1'b0;
        case (state_q)
            FETCH: begin
                if (wait_q == LAST_WAIT) begin
                    ir_c    = 1'b1;
                    wait_d  = '0;
                    state_d = DECODE;
                end else begin
                    wait_d = wait_q + WCW'(1);
                end
            end
            DECODE: begin
                // ALU opcode and flag-enable are latched here; the instruction is not looked at again.
                state_d = FETCH;
                case (decoded_instruction)
                    I_BRANCH: begin pc_c = 1'b1; br_c = 1'b1;                end
                    I_BZERO:  begin pc_c = 1'b1; br_c = zero_op;             end
                    I_BNZERO: begin pc_c = 1'b1; br_c = !zero_op;            end
                    I_BNEG:   begin pc_c = 1'b1; br_c = neg_op;              end
                    I_BNNEG:  begin pc_c = 1'b1; br_c = !neg_op;             end
                    I_BOV:    begin pc_c = 1'b1; br_c = signed_overflow | unsigned_overflow;    end
                    I_BNOV:   begin pc_c = 1'b1; br_c = !(signed_overflow | unsigned_overflow); end
                    I_ADD:    begin state_d = EXEC_ALU; alu_op_d = 2'b00; alu_flags_d = 1'b1; end
                    I_AND:    begin state_d = EXEC_ALU; alu_op_d = 2'b01; alu_flags_d = 1'b1; end
                    I_OR:     begin state_d = EXEC_ALU; alu_op_d = 2'b10; alu_flags_d = 1'b1; end
                    I_SUB:    begin state_d = EXEC_ALU; alu_op_d = 2'b11; alu_flags_d = 1'b1; end
                    I_MOVE:   begin state_d = EXEC_ALU; alu_op_d = 2'b10; alu_flags_d = 1'b0; end
                    I_LOAD:   state_d = LOAD_WAIT;
                    I_STORE:  state_d = STORE;
                    I_HALT:   state_d = HALT;
                    default:  pc_c = 1'b1;
                endcase
            end
            EXEC_ALU: begin
                wr_c    = 1'b1;
                pc_c    = 1'b1;
                op_c    = alu_op_q;
                fl_c    = alu_flags_q;
                state_d = FETCH;
            end
            LOAD_WAIT: begin
                as_c = 1'b1;
                if (wait_q == LAST_WAIT) begin
                    cs_c    = 1'b1;
                    wr_c    = 1'b1;
                    pc_c    = 1'b1;
                    wait_d  = '0;
                    state_d = FETCH;
                end else begin
                    wait_d = wait_q + WCW'(1);
                end
            end
            STORE: begin
                as_c    = 1'b1;
                rw_c    = 1'b1;
                pc_c    = 1'b1;
                state_d = FETCH;
            end
            HALT:    halt_c = 1'b1;
            default: state_d = FETCH;
        endcase
    end

    // While reset is held the outputs are forced low, so a strobe cut mid-cycle never completes.
    assign branch           = rst_n & br_c;
    assign pc_enable        = rst_n & pc_c;
    assign ir_enable        = rst_n & ir_c;
    assign addr_sel         = rst_n & as_c;
    assign c_sel            = rst_n & cs_c;
    assign operation        = rst_n ? op_c : 2'b00;
    assign write_reg_enable = rst_n & wr_c;
    assign flags_reg_enable = rst_n & fl_c;
    assign ram_write_enable = rst_n & rw_c;
    assign halt             = rst_n & halt_c;

`ifdef CU_RETIRED_CNT_EN
    logic [RET_CNT_W-1:0] ret_cnt_q, ret_cnt_d;

    assign ret_cnt_d = pc_c ? ret_cnt_q + RET_CNT_W'(1) : ret_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ret_cnt_q <= '0;
        end else begin
            ret_cnt_q <= ret_cnt_d;
        end
    end

    assign retired_count = ret_cnt_q;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: per-cycle expected output vectors are queued with the stimulus
// and compared as the DUT runs; one instance at RAM_LATENCY=1, one at RAM_LATENCY=3.
module tb_control_unit;
    import k_and_s_pkg::*;

    typedef struct packed {
        decoded_instruction_type di;
        logic [3:0]              fl;   // {zero, neg, unsigned_ov, signed_ov}
    } drv_t;

    logic clk;
    logic rst1_n, rst3_n;
    decoded_instruction_type di;
    logic z, n, uo, so;

    logic br1, pc1, ir1, as1, cs1, wr1, fl1, rw1, h1;
    logic br3, pc3, ir3, as3, cs3, wr3, fl3, rw3, h3;
    logic [1:0] op1, op3;
    logic [10:0] out1, out3;
`ifdef CU_RETIRED_CNT_EN
    logic [2:0] rc1, rc3;
`endif

    drv_t        drv_q[$];
    logic [10:0] exp_q[$];
    int          n_cmp, n_bad;
    bit          fresh, use3;

    control_unit #(.RAM_LATENCY(1), .RET_CNT_W(3)) dut1 (
        .clk(clk), .rst_n(rst1_n), .decoded_instruction(di),
        .zero_op(z), .neg_op(n), .unsigned_overflow(uo), .signed_overflow(so),
        .branch(br1), .pc_enable(pc1), .ir_enable(ir1), .addr_sel(as1), .c_sel(cs1),
        .operation(op1), .write_reg_enable(wr1), .flags_reg_enable(fl1),
        .ram_write_enable(rw1), .halt(h1)
`ifdef CU_RETIRED_CNT_EN
        , .retired_count(rc1)
`endif
    );

    control_unit #(.RAM_LATENCY(3), .RET_CNT_W(3)) dut3 (
        .clk(clk), .rst_n(rst3_n), .decoded_instruction(di),
        .zero_op(z), .neg_op(n), .unsigned_overflow(uo), .signed_overflow(so),
        .branch(br3), .pc_enable(pc3), .ir_enable(ir3), .addr_sel(as3), .c_sel(cs3),
        .operation(op3), .write_reg_enable(wr3), .flags_reg_enable(fl3),
        .ram_write_enable(rw3), .halt(h3)
`ifdef CU_RETIRED_CNT_EN
        , .retired_count(rc3)
`endif
    );

    assign out1 = {br1, pc1, ir1, as1, cs1, op1, wr1, fl1, rw1, h1};
    assign out3 = {br3, pc3, ir3, as3, cs3, op3, wr3, fl3, rw3, h3};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [10:0] ov(input logic b, input logic p, input logic i, input logic a,
                                       input logic c, input logic [1:0] o, input logic w,
                                       input logic f, input logic r, input logic h);
        return {b, p, i, a, c, o, w, f, r, h};
    endfunction

    function automatic drv_t junk();
        drv_t d;
        d.di = decoded_instruction_type'(4'($urandom_range(0, 15)));
        d.fl = 4'($urandom_range(0, 15));
        return d;
    endfunction

    task automatic push_cyc(input drv_t d, input logic [10:0] e);
        drv_q.push_back(d);
        exp_q.push_back(e);
    endtask

    // Expected output sequence of one instruction, built from the cycle-per-instruction table.
    task automatic push_instr(input int lat, input decoded_instruction_type ins, input logic [3:0] fl);
        drv_t d;
        logic c;
        logic [1:0] op;
        d.di = ins;
        d.fl = fl;
        for (int i = 0; i < lat; i++)
            push_cyc(junk(), ov(1'b0, 1'b0, (i == lat - 1), 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
        case (ins)
            I_BRANCH: c = 1'b1;
            I_BZERO:  c = fl[3];
            I_BNZERO: c = !fl[3];
            I_BNEG:   c = fl[2];
            I_BNNEG:  c = !fl[2];
            I_BOV:    c = fl[1] | fl[0];
            I_BNOV:   c = !(fl[1] | fl[0]);
            default:  c = 1'b0;
        endcase
        case (ins)
            I_ADD, I_SUB, I_AND, I_OR, I_MOVE: begin
                op = (ins == I_ADD) ? 2'b00 : (ins == I_AND) ? 2'b01 : (ins == I_SUB) ? 2'b11 : 2'b10;
                push_cyc(d, 11'd0);
                push_cyc(junk(), ov(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, op, 1'b1, (ins != I_MOVE), 1'b0, 1'b0));
            end
            I_LOAD: begin
                push_cyc(d, 11'd0);
                for (int i = 0; i < lat; i++)
                    push_cyc(junk(), ov(1'b0, (i == lat - 1), 1'b0, 1'b1, (i == lat - 1), 2'b00,
                                        (i == lat - 1), 1'b0, 1'b0, 1'b0));
            end
            I_STORE: begin
                push_cyc(d, 11'd0);
                push_cyc(junk(), ov(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0));
            end
            I_HALT:  push_cyc(d, 11'd0);
            default: push_cyc(d, ov(c, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
        endcase
    endtask

    task automatic drive_cycle(output logic [10:0] obs);
        drv_t d;
        if (!fresh) begin
            @(posedge clk);
            #1;
        end
        fresh = 1'b0;
        d = drv_q.pop_front();
        di = d.di;
        {z, n, uo, so} = d.fl;
        #1;
        obs = use3 ? out3 : out1;
    endtask

    task automatic apply_reset(input bit sel3);
        rst1_n = 1'b0;
        rst3_n = 1'b0;
        drv_q.delete();
        exp_q.delete();
        @(posedge clk);
        #1;
        use3 = sel3;
        if (sel3) rst3_n = 1'b1;
        else      rst1_n = 1'b1;
        fresh = 1'b1;
    endtask

    task automatic test_reset();
        logic [10:0] obs, e;
        int k;
        rst1_n = 1'b0;
        rst3_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            {di, z, n, uo, so} = junk();
            #1;
            n_cmp += 2;
            if (out1 !== 11'd0) begin
                n_bad++;
                $display("FAIL reset_l1 cyc%0d: got %b expected %b", i, out1, 11'd0);
            end
            if (out3 !== 11'd0) begin
                n_bad++;
                $display("FAIL reset_l3 cyc%0d: got %b expected %b", i, out3, 11'd0);
            end
        end
        apply_reset(1'b0);
        push_instr(1, I_NOP, 4'b0000);
        k = 0;
        while (exp_q.size() > 0) begin
            drive_cycle(obs);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL reset_release cyc%0d: got %b expected %b", k, obs, e);
            end
            k++;
        end
    endtask

    task automatic test_alu();
        logic [10:0] obs, e;
        int k;
        apply_reset(1'b0);
        push_instr(1, I_ADD, 4'($urandom_range(0, 15)));
        push_instr(1, I_MOVE, 4'($urandom_range(0, 15)));
        push_instr(1, I_SUB, 4'($urandom_range(0, 15)));
        push_instr(1, I_AND, 4'($urandom_range(0, 15)));
        push_instr(1, I_OR, 4'($urandom_range(0, 15)));
        push_instr(1, I_LOAD, 4'($urandom_range(0, 15)));
        push_instr(1, I_STORE, 4'($urandom_range(0, 15)));
        push_instr(1, I_ADD, 4'($urandom_range(0, 15)));
        k = 0;
        while (exp_q.size() > 0) begin
            drive_cycle(obs);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL alu_l1 cyc%0d: got %b expected %b", k, obs, e);
            end
            k++;
        end
    endtask

    task automatic test_latency3();
        logic [10:0] obs, e;
        int k;
        apply_reset(1'b1);
        push_instr(3, I_LOAD, 4'b0000);
        push_instr(3, I_STORE, 4'b1111);
        push_instr(3, I_SUB, 4'b0101);
        push_instr(3, I_MOVE, 4'b0000);
        push_instr(3, I_BNZERO, 4'b0000);
        push_instr(3, I_LOAD, 4'b1000);
        k = 0;
        while (exp_q.size() > 0) begin
            drive_cycle(obs);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL latency3 cyc%0d: got %b expected %b", k, obs, e);
            end
            k++;
        end
    endtask

    task automatic test_branches();
        logic [10:0] obs, e;
        int k;
        apply_reset(1'b0);
        push_instr(1, I_BZERO, 4'b1000);
        push_instr(1, I_BZERO, 4'b0111);
        push_instr(1, I_BOV, 4'b0010);
        push_instr(1, I_BOV, 4'b1100);
        push_instr(1, I_BNOV, 4'b0001);
        push_instr(1, I_BNOV, 4'b0000);
        push_instr(1, I_BNEG, 4'b0100);
        push_instr(1, I_BNNEG, 4'b0100);
        push_instr(1, I_BNNEG, 4'b1011);
        push_instr(1, I_BNZERO, 4'b1000);
        push_instr(1, I_BRANCH, 4'b0000);
        push_instr(1, I_NOP, 4'b1111);
        k = 0;
        while (exp_q.size() > 0) begin
            drive_cycle(obs);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL branch cyc%0d: got %b expected %b", k, obs, e);
            end
            k++;
        end
    endtask

    task automatic test_halt();
        logic [10:0] obs, e;
        int k;
        apply_reset(1'b0);
        push_instr(1, I_HALT, 4'b0000);
        for (int i = 0; i < 20; i++)
            push_cyc(junk(), ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1));
        k = 0;
        while (exp_q.size() > 0) begin
            drive_cycle(obs);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL halt cyc%0d: got %b expected %b", k, obs, e);
            end
            k++;
        end
        #1 rst1_n = 1'b0;
        #1;
        n_cmp++;
        if (out1 !== 11'd0) begin
            n_bad++;
            $display("FAIL halt_async_reset: got %b expected %b", out1, 11'd0);
        end
        @(posedge clk);
        #1 rst1_n = 1'b1;
        fresh = 1'b1;
        push_instr(1, I_ADD, 4'b0000);
        k = 0;
        while (exp_q.size() > 0) begin
            drive_cycle(obs);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL halt_resume cyc%0d: got %b expected %b", k, obs, e);
            end
            k++;
        end
    endtask

    task automatic test_reset_mid_store();
        logic [10:0] obs, e;
        int k;
        apply_reset(1'b0);
        push_instr(1, I_ADD, 4'b0000);
        push_instr(1, I_STORE, 4'b0000);
        k = 0;
        while (exp_q.size() > 0) begin
            drive_cycle(obs);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL mid_store cyc%0d: got %b expected %b", k, obs, e);
            end
            k++;
        end
        #1 rst1_n = 1'b0;
        #1;
        n_cmp++;
        if (out1 !== 11'd0) begin
            n_bad++;
            $display("FAIL mid_store_reset: got %b expected %b", out1, 11'd0);
        end
`ifdef CU_RETIRED_CNT_EN
        n_cmp++;
        if (rc1 !== 3'd0) begin
            n_bad++;
            $display("FAIL mid_store_count: got %0d expected 0", rc1);
        end
`endif
    endtask

`ifdef CU_RETIRED_CNT_EN
    task automatic test_retired_count();
        logic [10:0] obs, e;
        int k;
        apply_reset(1'b0);
        for (int i = 0; i < 9; i++) push_instr(1, I_NOP, 4'b0000);
        push_instr(1, I_HALT, 4'b0000);
        for (int i = 0; i < 6; i++)
            push_cyc(junk(), ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1));
        k = 0;
        while (exp_q.size() > 0) begin
            drive_cycle(obs);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL retired_seq cyc%0d: got %b expected %b", k, obs, e);
            end
            if (k >= 20) begin
                n_cmp++;
                if (rc1 !== 3'd1) begin
                    n_bad++;
                    $display("FAIL retired_count cyc%0d: got %0d expected 1", k, rc1);
                end
            end
            k++;
        end
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_bad = 0;
        fresh = 1'b0;
        use3  = 1'b0;
        rst1_n = 1'b0;
        rst3_n = 1'b0;
        di = I_NOP;
        {z, n, uo, so} = 4'b0000;
        test_reset();
        test_alu();
        test_latency3();
        test_branches();
        test_halt();
        test_reset_mid_store();
`ifdef CU_RETIRED_CNT_EN
        test_retired_count();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit exceeded");
    end

endmodule
